exe_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline. It consumes the ID/EX pipeline register outputs and feeds the EX/MEM register.
- Single-cycle ALU for simple ops, plus an iterative 32-cycle signed multiply/divide unit.
- While a MUL/DIV is in progress it asserts `stall`, which freezes PC, IF/ID and ID/EX.
- It also computes the branch target for the IF stage.

---
 rtl/exe_stage_if.sv | 34 +++
 rtl/exe_stage.sv | 140 ++++++++++++++
 tb/tb_exe_stage.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/exe_stage_if.sv
// rtl/exe_stage_if.sv - ID/EX-to-EX/MEM signal bundle for the execute stage
interface exe_stage_if;
  logic [31:0] PC;
  logic [4:0]  dest;
  logic [31:0] Reg2;
  logic [31:0] Val1;
  logic [31:0] Val2;
  logic        Br_taken;
  logic [3:0]  EXE_cmd;
  logic        MEM_R_en;
  logic        MEM_W_en;
  logic        WB_en;
  logic [31:0] ALU_result;
  logic [31:0] Br_addr;
  logic        Br_taken_out;
  logic [4:0]  dest_out;
  logic [31:0] Reg2_out;
  logic        MEM_R_en_out;
  logic        MEM_W_en_out;
  logic        WB_en_out;
  logic        stall;

  modport master (
    output PC, dest, Reg2, Val1, Val2, Br_taken, EXE_cmd, MEM_R_en, MEM_W_en, WB_en,
    input  ALU_result, Br_addr, Br_taken_out, dest_out, Reg2_out,
           MEM_R_en_out, MEM_W_en_out, WB_en_out, stall
  );

  modport slave (
    input  PC, dest, Reg2, Val1, Val2, Br_taken, EXE_cmd, MEM_R_en, MEM_W_en, WB_en,
    output ALU_result, Br_addr, Br_taken_out, dest_out, Reg2_out,
           MEM_R_en_out, MEM_W_en_out, WB_en_out, stall
  );
endinterface

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - MIPS execute stage: single-cycle ALU plus iterative signed MUL/DIV
// MUL/DIV run on operand magnitudes for 32 iterations; the sign is applied at the end.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  exe_stage_if.slave  bus
);

  localparam logic [3:0] CMD_MUL = 4'b1100;
  localparam logic [3:0] CMD_DIV = 4'b1101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        op_div;
  logic        neg_res;
  logic        div_zero;
  logic [31:0] r_a;    // MUL: shifting multiplicand; DIV: dividend shifting into quotient
  logic [31:0] r_b;    // MUL: shifting multiplier;   DIV: divisor
  logic [31:0] r_acc;  // MUL: product accumulator;   DIV: partial remainder
  logic        is_md;
  logic        stall_int;
  logic        bubble;
  logic [31:0] alu_out;
  logic [31:0] md_mag;
  logic [31:0] md_res;
  logic [32:0] rem_sh;
  logic [32:0] trial;

  assign is_md  = (bus.EXE_cmd == CMD_MUL) || (bus.EXE_cmd == CMD_DIV);
  assign rem_sh = {r_acc, r_a[31]};
  assign trial  = rem_sh - {1'b0, r_b};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand capture in IDLE and one shift-add / restoring-divide step per BUSY cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 5'd0;
      op_div   <= 1'b0;
      neg_res  <= 1'b0;
      div_zero <= 1'b0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_acc    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (is_md) begin
            cnt      <= 5'd0;
            op_div   <= (bus.EXE_cmd == CMD_DIV);
            neg_res  <= bus.Val1[31] ^ bus.Val2[31];
            div_zero <= (bus.EXE_cmd == CMD_DIV) && (bus.Val2 == 32'd0);
            r_a      <= bus.Val1[31] ? -bus.Val1 : bus.Val1;
            r_b      <= bus.Val2[31] ? -bus.Val2 : bus.Val2;
            r_acc    <= 32'd0;
          end
        end
        BUSY: begin
          cnt <= cnt + 5'd1;
          if (op_div) begin
            if (!trial[32]) begin
              r_acc <= trial[31:0];
              r_a   <= {r_a[30:0], 1'b1};
            end else begin
              r_acc <= rem_sh[31:0];
              r_a   <= {r_a[30:0], 1'b0};
            end
          end else begin
            if (r_b[0]) r_acc <= r_acc + r_a;
            r_a <= {r_a[30:0], 1'b0};
            r_b <= {1'b0, r_b[31:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and stall/bubble decode
  always_comb begin
    state_nxt = state;
    stall_int = 1'b0;
    bubble    = 1'b0;
    case (state)
      IDLE: begin
        if (is_md) begin
          stall_int = 1'b1;
          bubble    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        stall_int = 1'b1;
        bubble    = 1'b1;
        if (cnt == 5'd31) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle ALU; MUL/DIV codes yield 0 here and are served from the iterative unit
  always_comb begin
    alu_out = 32'd0;
    case (bus.EXE_cmd)
      4'b0000: alu_out = bus.Val1 + bus.Val2;
      4'b0010: alu_out = bus.Val1 - bus.Val2;
      4'b0100: alu_out = bus.Val1 & bus.Val2;
      4'b0101: alu_out = bus.Val1 | bus.Val2;
      4'b0110: alu_out = ~(bus.Val1 | bus.Val2);
      4'b0111: alu_out = bus.Val1 ^ bus.Val2;
      4'b1000: alu_out = bus.Val1 << bus.Val2[4:0];
      4'b1001: alu_out = $signed(bus.Val1) >>> bus.Val2[4:0];
      4'b1010: alu_out = bus.Val1 >> bus.Val2[4:0];
      default: alu_out = 32'd0;
    endcase
  end

  // Divide by zero reports all ones whatever the operand signs
  assign md_mag = op_div ? r_a : r_acc;
  assign md_res = div_zero ? 32'hFFFF_FFFF : (neg_res ? -md_mag : md_mag);

  // Reset drops the freeze request at once, even if a MUL/DIV is still presented
  assign bus.stall        = stall_int & ~rst;
  assign bus.ALU_result   = (state == DONE) ? md_res : alu_out;
  assign bus.Br_addr      = bus.PC + {bus.Val2[29:0], 2'b00};
  assign bus.Br_taken_out = bus.Br_taken;
  assign bus.dest_out     = bus.dest;
  assign bus.Reg2_out     = bus.Reg2;
  assign bus.MEM_R_en_out = bus.MEM_R_en & ~(bubble & ~rst);
  assign bus.MEM_W_en_out = bus.MEM_W_en & ~(bubble & ~rst);
  assign bus.WB_en_out    = bus.WB_en & ~(bubble & ~rst);

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - directed bench for exe_stage with a result scoreboard
module tb_exe_stage;

  localparam logic [3:0] C_ADD = 4'b0000;
  localparam logic [3:0] C_SUB = 4'b0010;
  localparam logic [3:0] C_NOR = 4'b0110;
  localparam logic [3:0] C_SLL = 4'b1000;
  localparam logic [3:0] C_SRA = 4'b1001;
  localparam logic [3:0] C_SRL = 4'b1010;
  localparam logic [3:0] C_MUL = 4'b1100;
  localparam logic [3:0] C_DIV = 4'b1101;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  exe_stage_if bus ();

  exe_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic signed [31:0] q;
    if (cmd == C_MUL) begin
      p = $signed(a) * $signed(b);
      return p[31:0];
    end
    if (b == 32'd0) return 32'hFFFF_FFFF;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
    q = $signed(a) / $signed(b);
    return q;
  endfunction

  task automatic drive(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2, input logic wb);
    bus.EXE_cmd = cmd;
    bus.Val1    = v1;
    bus.Val2    = v2;
    bus.WB_en   = wb;
  endtask

  task automatic alu(input string tag, input logic [3:0] cmd, input logic [31:0] v1,
                     input logic [31:0] v2, input logic [31:0] exp);
    @(posedge clk);
    #1 drive(cmd, v1, v2, 1'b1);
    #1;
    check(tag, bus.ALU_result, exp);
    check({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
  endtask

  // Applies a MUL/DIV just after a clock edge, then follows it until stall drops.
  task automatic run_md(input string tag, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    int  n    = 0;
    int  bad  = 0;
    bit  done = 0;
    logic [31:0] exp;
    @(posedge clk);
    #1 drive(cmd, a, b, 1'b1);
    exp_q.push_back(model(cmd, a, b));
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus.stall) begin
        n++;
        if (bus.WB_en_out !== 1'b0 || bus.MEM_R_en_out !== 1'b0) bad++;
      end else begin
        done = 1;
      end
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_stall_cycles"}, n, 32'd33);
    check({tag, "_bubble"}, bad, 32'd0);
    exp = exp_q.pop_front();
    check({tag, "_result"}, bus.ALU_result, exp);
    check({tag, "_wb_out"}, {31'd0, bus.WB_en_out}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.PC       = 32'd0;
    bus.dest     = 5'd0;
    bus.Reg2     = 32'd0;
    bus.Br_taken = 1'b0;
    bus.MEM_R_en = 1'b0;
    bus.MEM_W_en = 1'b0;
    drive(C_ADD, 32'd0, 32'd0, 1'b0);
    #2;
    check("rst_alu", bus.ALU_result, 32'd0);
    check("rst_br_addr", bus.Br_addr, 32'd0);
    check("rst_ctrl", {27'd0, bus.Br_taken_out, bus.MEM_R_en_out, bus.MEM_W_en_out, bus.WB_en_out, bus.stall}, 32'd0);
    check("rst_dest", {27'd0, bus.dest_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    alu("add", C_ADD, 32'd5, 32'hFFFF_FFFD, 32'd2);
    check("add_wb_out", {31'd0, bus.WB_en_out}, 32'd1);
    bus.dest = 5'd17; bus.Reg2 = 32'hCAFE_0001; bus.MEM_R_en = 1'b1;
    #1;
    check("pass_dest", {27'd0, bus.dest_out}, 32'd17);
    check("pass_reg2", bus.Reg2_out, 32'hCAFE_0001);
    check("pass_mem_r", {31'd0, bus.MEM_R_en_out}, 32'd1);

    bus.PC = 32'h100; bus.Val2 = 32'hFFFF_FFFF; bus.Br_taken = 1'b1;
    #1;
    check("br_addr", bus.Br_addr, 32'h0000_00FC);
    check("br_taken_out", {31'd0, bus.Br_taken_out}, 32'd1);

    alu("sub", C_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE);
    alu("nor", C_NOR, 32'h0F0F_0000, 32'h0000_00F0, 32'hF0F0_FF0F);
    alu("sll", C_SLL, 32'd1, 32'h0000_003F, 32'h8000_0000);
    alu("sra", C_SRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
    alu("srl", C_SRL, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000);
    alu("undef", 4'b0011, 32'h1234_5678, 32'd9, 32'd0);

    run_md("mul_neg", C_MUL, 32'hFFFF_FFF9, 32'd6);
    run_md("div_neg", C_DIV, 32'hFFFF_FFF9, 32'd2);
    run_md("div_zero", C_DIV, 32'd7, 32'd0);
    run_md("div_ovf", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md("mul_ovf", C_MUL, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md("div_negzero", C_DIV, 32'hFFFF_FFF9, 32'd0);
    run_md("mul_rand", C_MUL, $urandom, $urandom);
    run_md("div_rand", C_DIV, $urandom, $urandom_range(1, 5000));

    @(posedge clk);
    #1 drive(C_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    bus.PC = 32'h200;
    repeat (11) @(posedge clk);
    #1;
    check("busy_stall", {31'd0, bus.stall}, 32'd1);
    check("busy_br_addr", bus.Br_addr, 32'h0000_0208);
    rst = 1'b1;
    #1;
    check("rst_stall_drop", {31'd0, bus.stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(C_ADD, 32'd0, 32'd0, 1'b0);
    run_md("div_after_rst", C_DIV, 32'hFFFF_FFF9, 32'd2);

    run_md("b2b_div", C_DIV, 32'd100, 32'hFFFF_FFFD);
    run_md("b2b_mul", C_MUL, 32'd12345, 32'hFFFF_FF00);

    @(posedge clk);
    #1 drive(C_ADD, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("idle_after", {31'd0, bus.stall}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
